// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap / mret sequencer between commit and the CSR file.
// Latency: event accepted at T -> flush T+1 -> CSR strobe one cycle after flush_ack -> redirect next cycle.
// Backpressure: commit_ready drops whenever an event is taken or the FSM is busy; flush_ack gates the CSR update.
//
// Ports:
//   CLK, RST                 clock / asynchronous active-high reset
//   commit_*                 oldest instruction offered by commit (valid, pc, exception, cause, tval, mret)
//   commit_ready             instruction retires normally this cycle (combinational)
//   flush / flush_ack        pipeline kill pulse and drained acknowledge
//   redirect_valid/_pc       front-end redirect
//   isTrap / isXRet          CSR update strobes, *_except_in carry the new CSR values
//   *_csr_out                current CSR contents
// Optional feature: define TRAP_VECTORED_INT_EN for vectored interrupt targets (mtvec[1:0]==2'b01).

module trap_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        commit_is_except,
  input  logic [3:0]  commit_cause,
  input  logic [63:0] commit_tval,
  input  logic        commit_is_mret,
  output logic        commit_ready,
  output logic        flush,
  input  logic        flush_ack,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        isTrap,
  output logic        isXRet,
  output logic [63:0] mstatus_except_in,
  output logic [63:0] mepc_except_in,
  output logic [63:0] mcause_except_in,
  output logic [63:0] mtval_except_in,
  input  logic [63:0] mstatus_csr_out,
  input  logic [63:0] mie_csr_out,
  input  logic [63:0] mip_csr_out,
  input  logic [63:0] mepc_csr_out,
  input  logic [63:0] mtvec_csr_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_ACK,
    ST_UPDATE,
    ST_REDIRECT
  } state_t;

  state_t      r_state;
  logic        r_is_int;
  logic        r_is_mret;
  logic [63:0] r_epc;
  logic [3:0]  r_cause;
  logic [63:0] r_tval;
  logic        r_flush;
  logic        r_trap;
  logic        r_xret;
  logic        r_redir;

  logic [63:0] w_int_bits;
  logic        w_int_pend;
  logic [3:0]  w_int_code;
  logic        w_take;
  logic [63:0] w_base;
  logic [63:0] w_trap_target;

  // Only MEI/MTI/MSI are considered; MEI > MSI > MTI.
  assign w_int_bits = mip_csr_out & mie_csr_out & 64'h888;
  assign w_int_pend = mstatus_csr_out[3] & (|w_int_bits);
  assign w_int_code = w_int_bits[11] ? 4'd11 : (w_int_bits[3] ? 4'd3 : 4'd7);
  assign w_take     = commit_valid & (w_int_pend | commit_is_except | commit_is_mret);

  assign commit_ready = (r_state == ST_IDLE) & commit_valid & ~w_take;

  assign w_base = {mtvec_csr_out[63:2], 2'b00};
`ifdef TRAP_VECTORED_INT_EN
  assign w_trap_target = (r_is_int && (mtvec_csr_out[1:0] == 2'b01))
                         ? (w_base + {58'd0, r_cause, 2'b00}) : w_base;
`else
  // Mode bits have no effect without vectoring.
  logic w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = ^mtvec_csr_out[1:0];
  assign w_trap_target = w_base;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_is_int  <= 1'b0;
      r_is_mret <= 1'b0;
      r_epc     <= 64'd0;
      r_cause   <= 4'd0;
      r_tval    <= 64'd0;
      r_flush   <= 1'b0;
      r_trap    <= 1'b0;
      r_xret    <= 1'b0;
      r_redir   <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      r_trap  <= 1'b0;
      r_xret  <= 1'b0;
      r_redir <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            // Interrupt wins over exception wins over mret; a faulting
            // instruction hit by an interrupt re-raises after the handler.
            r_state   <= ST_FLUSH;
            r_flush   <= 1'b1;
            r_is_int  <= w_int_pend;
            r_is_mret <= ~w_int_pend & ~commit_is_except;
            r_epc     <= commit_pc;
            r_cause   <= w_int_pend ? w_int_code : (commit_is_except ? commit_cause : 4'd0);
            r_tval    <= (~w_int_pend & commit_is_except) ? commit_tval : 64'd0;
          end
        end
        ST_FLUSH, ST_WAIT_ACK: begin
          if (flush_ack) begin
            r_state <= ST_UPDATE;
            r_trap  <= ~r_is_mret;
            r_xret  <= r_is_mret;
          end else begin
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_UPDATE: begin
          r_state <= ST_REDIRECT;
          r_redir <= 1'b1;
        end
        ST_REDIRECT: begin
          r_state   <= ST_IDLE;
          r_is_int  <= 1'b0;
          r_is_mret <= 1'b0;
          r_epc     <= 64'd0;
          r_cause   <= 4'd0;
          r_tval    <= 64'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign flush          = r_flush;
  assign isTrap         = r_trap;
  assign isXRet         = r_xret;
  assign redirect_valid = r_redir;

  // CSR values use the CSR inputs as seen during UPDATE; zero elsewhere.
  always_comb begin
    mstatus_except_in = 64'd0;
    mepc_except_in    = 64'd0;
    mcause_except_in  = 64'd0;
    mtval_except_in   = 64'd0;
    if (r_trap) begin
      mstatus_except_in        = mstatus_csr_out;
      mstatus_except_in[7]     = mstatus_csr_out[3];
      mstatus_except_in[3]     = 1'b0;
      mstatus_except_in[12:11] = 2'b11;
      mepc_except_in           = {r_epc[63:1], 1'b0};
      mcause_except_in         = {r_is_int, 59'd0, r_cause};
      mtval_except_in          = r_tval;
    end else if (r_xret) begin
      mstatus_except_in        = mstatus_csr_out;
      mstatus_except_in[3]     = mstatus_csr_out[7];
      mstatus_except_in[7]     = 1'b1;
      mstatus_except_in[12:11] = 2'b11;
    end
  end

  always_comb begin
    redirect_pc = 64'd0;
    if (r_redir) begin
      redirect_pc = r_is_mret ? mepc_csr_out : w_trap_target;
    end
  end

endmodule
